// File: rtl/noc_packetizer_if.sv
// noc_packetizer_if: message request, payload stream and router flit link bundle
interface noc_packetizer_if;
  logic msg_valid, msg_ready;
  logic [3:0] msg_dest, msg_len;
  logic [31:0] pl_data;
  logic pl_valid, pl_ready;
  logic [31:0] flit_data;
  logic flit_valid, flit_ready, flit_head, flit_tail;
  logic busy;
  modport master (
    output msg_valid, msg_dest, msg_len, pl_data, pl_valid, flit_ready,
    input msg_ready, pl_ready, flit_data, flit_valid, flit_head, flit_tail, busy
  );
  modport slave (
    input msg_valid, msg_dest, msg_len, pl_data, pl_valid, flit_ready,
    output msg_ready, pl_ready, flit_data, flit_valid, flit_head, flit_tail, busy
  );
endinterface

// File: rtl/noc_packetizer.sv
// noc_packetizer: turns a message request plus payload words into a head/payload/tail flit packet
module noc_packetizer #(
  parameter logic [3:0] SRC_ID = 4'd0,
  parameter int DEST_W = 4
) (
  input logic clk,
  input logic reset,
  noc_packetizer_if.slave b
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, next_state;
  logic [3:0] remaining;
  logic [7:0] seq;
  logic msg_take, pl_take, drain;
  assign msg_take = b.msg_valid & b.msg_ready;
  assign pl_take = b.pl_valid & b.pl_ready;
  assign drain = b.flit_valid & b.flit_ready;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (msg_take ? SEND : IDLE) : (drain && b.flit_tail ? IDLE : SEND);
  // Readies depend only on state and the output register, never on the valids
  always_comb begin
    b.msg_ready = !reset && state == IDLE;
    b.pl_ready = !reset && state == SEND && remaining != 4'd0 && (!b.flit_valid || b.flit_ready);
    b.busy = state != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      seq <= '0;
      remaining <= '0;
      b.flit_valid <= 1'b0;
      b.flit_data <= '0;
      b.flit_head <= 1'b0;
      b.flit_tail <= 1'b0;
    end else begin
      if (drain && b.flit_head) seq <= seq + 8'd1;
      if (msg_take) begin
        remaining <= b.msg_len;
        b.flit_data <= {b.msg_dest[DEST_W-1:0], SRC_ID, b.msg_len, seq, 12'd0};
        b.flit_valid <= 1'b1;
        b.flit_head <= 1'b1;
        b.flit_tail <= b.msg_len == 4'd0;
      end else if (pl_take) begin
        remaining <= remaining - 4'd1;
        b.flit_data <= b.pl_data;
        b.flit_valid <= 1'b1;
        b.flit_head <= 1'b0;
        b.flit_tail <= remaining == 4'd1;
      end else if (drain) b.flit_valid <= 1'b0;
    end
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: table-driven, hand-sequenced and randomized checks against a packet-level model
module tb_noc_packetizer;
  localparam logic [3:0] SRC = 4'd2;
  typedef struct { logic [31:0] d; logic h, t; } flit_t;
  typedef struct { logic [3:0] dest, len; int gap, rmode; logic [31:0] head; } vec_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  noc_packetizer_if b();
  noc_packetizer #(.SRC_ID(SRC), .DEST_W(4)) dut (.clk(clk), .reset(reset), .b(b));
  flit_t exp_q[$];
  vec_t tbl[5];
  int checks = 0, failures = 0;
  int rmode = 0, cyc = 0, ncyc = 0, tail_cyc = -100, head_cyc = -100;
  bit b2b = 1'b0, sb_on = 1'b1;
  logic [7:0] seq_m = 8'd0;
  logic [31:0] last_head = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // mode 0: always ready, 1: ready one cycle in three, 2: random ~75%
  initial begin
    b.flit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      b.flit_ready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    flit_t pv, e;
    bit stall;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) stall = 1'b0;
      else begin
        if (stall) begin
          chk1("hold_valid", b.flit_valid, 1'b1);
          chk("hold_data", b.flit_data, pv.d);
          chk1("hold_head", b.flit_head, pv.h);
          chk1("hold_tail", b.flit_tail, pv.t);
        end
        if (b.flit_valid && !b.flit_ready) chk1("stall_pl_ready", b.pl_ready, 1'b0);
        if (ncyc == tail_cyc + 1) chk1("post_tail_gap", b.flit_valid, 1'b0);
        stall = b.flit_valid && !b.flit_ready;
        pv = '{b.flit_data, b.flit_head, b.flit_tail};
        if (b.flit_valid && b.flit_ready) begin
          if (b.flit_head) begin
            if (b2b && tail_cyc >= 0) chk("b2b_spacing", ncyc - tail_cyc, 2);
            last_head = b.flit_data;
            head_cyc = ncyc;
          end
          if (b.flit_tail) tail_cyc = ncyc;
          if (sb_on) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_flit: got %h with nothing expected", b.flit_data);
            end else begin
              e = exp_q.pop_front();
              chk("flit_data", b.flit_data, e.d);
              chk1("flit_head", b.flit_head, e.h);
              chk1("flit_tail", b.flit_tail, e.t);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    b.msg_valid = 1'b0;
    b.pl_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    seq_m = 8'd0;
    tail_cyc = -100;
  endtask

  task automatic send(input logic [3:0] dest, input logic [3:0] len, input int gap);
    logic [31:0] w;
    int n;
    exp_q.push_back('{{dest, SRC, len, seq_m, 12'd0}, 1'b1, len == 4'd0});
    seq_m++;
    b.msg_valid = 1'b1;
    b.msg_dest = dest;
    b.msg_len = len;
    n = 0;
    do begin @(negedge clk); n++; end while (!b.msg_ready && n < 300);
    if (!b.msg_ready) begin
      timeout("msg_accept");
      b.msg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 b.msg_valid = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      if (i > 0) begin
        b.pl_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          if (g == gap - 1 && gap >= 2 && rmode == 0) chk1("gap_flit_valid", b.flit_valid, 1'b0);
          @(posedge clk);
          #1;
        end
      end
      w = $urandom;
      exp_q.push_back('{w, 1'b0, i == int'(len) - 1});
      b.pl_valid = 1'b1;
      b.pl_data = w;
      n = 0;
      do begin @(negedge clk); n++; end while (!b.pl_ready && n < 300);
      if (!b.pl_ready) begin
        timeout("pl_accept");
        b.pl_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1 b.pl_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk1("busy_after", b.busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{4'h5, 4'd0, 0, 0, 32'h5200_0000};
    tbl[1] = '{4'h3, 4'd2, 0, 0, 32'h3220_1000};
    tbl[2] = '{4'hA, 4'd3, 0, 1, 32'hA230_2000};
    tbl[3] = '{4'hF, 4'd4, 2, 0, 32'hF240_3000};
    tbl[4] = '{4'h0, 4'd15, 0, 2, 32'h02F0_4000};
    b.msg_valid = 1'b0;
    b.msg_dest = '0;
    b.msg_len = '0;
    b.pl_valid = 1'b0;
    b.pl_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_msg_ready", b.msg_ready, 1'b0);
    chk1("rst_pl_ready", b.pl_ready, 1'b0);
    chk1("rst_flit_valid", b.flit_valid, 1'b0);
    chk("rst_flit_data", b.flit_data, 0);
    chk1("rst_flit_head", b.flit_head, 1'b0);
    chk1("rst_flit_tail", b.flit_tail, 1'b0);
    chk1("rst_busy", b.busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    b.pl_valid = 1'b1;
    b.pl_data = 32'h1234_5678;
    repeat (2) begin
      @(negedge clk);
      chk1("idle_msg_ready", b.msg_ready, 1'b1);
      chk1("idle_pl_ready", b.pl_ready, 1'b0);
      chk1("idle_busy", b.busy, 1'b0);
    end
    @(posedge clk);
    #1 b.pl_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      rmode = tbl[i].rmode;
      send(tbl[i].dest, tbl[i].len, tbl[i].gap);
      drain();
      rmode = 0;
      chk("tbl_head", last_head, tbl[i].head);
      if (tbl[i].gap == 0 && tbl[i].rmode == 0) chk("tbl_burst", tail_cyc - head_cyc, int'(tbl[i].len));
    end

    do_reset();
    b2b = 1'b1;
    repeat (257) send(4'h9, 4'd1, 0);
    drain();
    b2b = 1'b0;
    chk("seq_wrap", 32'(last_head[19:12]), 0);

    do_reset();
    sb_on = 1'b0;
    b.msg_valid = 1'b1;
    b.msg_dest = 4'h7;
    b.msg_len = 4'd5;
    @(negedge clk);
    chk1("mp_msg_ready", b.msg_ready, 1'b1);
    @(posedge clk);
    #1 b.msg_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b.pl_valid = 1'b1;
      b.pl_data = 32'hBEEF_0000 + i;
      @(negedge clk);
      chk1("mp_pl_ready", b.pl_ready, 1'b1);
      @(posedge clk);
      #1;
    end
    b.pl_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk1("mp_msg_ready_rst", b.msg_ready, 1'b0);
    chk1("mp_pl_ready_rst", b.pl_ready, 1'b0);
    chk1("mp_flit_valid", b.flit_valid, 1'b0);
    chk("mp_flit_data", b.flit_data, 0);
    chk1("mp_flit_head", b.flit_head, 1'b0);
    chk1("mp_flit_tail", b.flit_tail, 1'b0);
    chk1("mp_busy", b.busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    seq_m = 8'd0;
    tail_cyc = -100;
    sb_on = 1'b1;
    send(4'h7, 4'd1, 0);
    drain();
    chk("mp_new_head", last_head, 32'h7210_0000);

    rmode = 2;
    repeat (40) send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    drain();
    rmode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
